// File: rtl/jtag_pkg.sv
// TAP state encoding, default opcodes and the standard TMS next-state function.
// Shared by the TAP top, its shift registers and any debug logic decoding the state output.
package jtag_pkg;

  typedef enum logic [3:0] {
    TestLogicReset = 4'd0,
    RunTestIdle    = 4'd1,
    SelectDrScan   = 4'd2,
    CaptureDr      = 4'd3,
    ShiftDr        = 4'd4,
    Exit1Dr        = 4'd5,
    PauseDr        = 4'd6,
    Exit2Dr        = 4'd7,
    UpdateDr       = 4'd8,
    SelectIrScan   = 4'd9,
    CaptureIr      = 4'd10,
    ShiftIr        = 4'd11,
    Exit1Ir        = 4'd12,
    PauseIr        = 4'd13,
    Exit2Ir        = 4'd14,
    UpdateIr       = 4'd15
  } tap_state_e;

  localparam int unsigned DEF_IR_WIDTH      = 4;
  localparam int unsigned DEF_USER_DR_WIDTH = 8;
  localparam logic [31:0] DEF_IDCODE        = 32'h0000_FAF0;
  localparam logic [3:0]  DEF_OP_IDCODE     = 4'h1;
  localparam logic [3:0]  DEF_OP_USER       = 4'h8;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TestLogicReset: n = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    n = tms ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   n = tms ? SelectIrScan   : CaptureDr;
      CaptureDr:      n = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        n = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        n = tms ? UpdateDr       : PauseDr;
      PauseDr:        n = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        n = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       n = tms ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   n = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      n = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        n = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        n = tms ? UpdateIr       : PauseIr;
      PauseIr:        n = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        n = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       n = tms ? SelectDrScan   : RunTestIdle;
      default:        n = TestLogicReset;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// Capture/shift/hold register: parallel load on capture, right shift with serial_in into the MSB on shift.
// One tck per operation; capture wins over shift; synchronous active-low clear.
module jtag_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH:0]   sr_cat;

  always_comb begin
    sr_cat = {serial_in, sr_q};
    sr_d   = sr_q;
    if (capture) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = sr_cat[WIDTH:1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/jtag_tap.sv
// IEEE 1149.1-style TAP with instruction register and IDCODE/BYPASS/USER data registers; tdo is the LSB of the selected register.
// JTAG_SYS_RESET_EN adds a sys_reset input, synchronised to tck, whose rising edge resets the TAP 3 tck later.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH      = DEF_IR_WIDTH,
  parameter logic [31:0]          IDCODE        = DEF_IDCODE,
  parameter int unsigned          USER_DR_WIDTH = DEF_USER_DR_WIDTH,
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE     = IR_WIDTH'(DEF_OP_IDCODE),
  parameter logic [IR_WIDTH-1:0]  OP_USER       = IR_WIDTH'(DEF_OP_USER)
) (
  input  logic                     tck,
  input  logic                     trst_n,
  input  logic                     tms,
  input  logic                     tdi,
`ifdef JTAG_SYS_RESET_EN
  input  logic                     sys_reset,
`endif
  output logic                     tdo,
  output logic                     tdo_oe,
  output logic [3:0]               state,
  output logic [IR_WIDTH-1:0]      ir,
  output logic                     in_reset,
  input  logic [USER_DR_WIDTH-1:0] user_capture,
  output logic [USER_DR_WIDTH-1:0] user_update,
  output logic                     user_update_valid
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic rst_n;

`ifdef JTAG_SYS_RESET_EN
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], sys_reset};
  end

  always_ff @(posedge tck) begin
    if (!trst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Single-cycle reset on the edge entering the last stage, so a held sys_reset resets once.
  assign rst_n = trst_n & ~(sync_q[1] & ~sync_q[2]);
`else
  assign rst_n = trst_n;
`endif

  tap_state_e                state_q, state_d;
  logic [IR_WIDTH-1:0]       ir_q, ir_d;
  logic                      byp_q, byp_d;
  logic [USER_DR_WIDTH-1:0]  user_update_q, user_update_d;
  logic                      user_valid_q, user_valid_d;

  logic [IR_WIDTH-1:0]       ir_sr;
  logic [31:0]               id_sr;
  logic [USER_DR_WIDTH-1:0]  usr_sr;
  logic                      unused_id;

  logic sel_idcode, sel_user, sel_byp;
  logic capture_dr, shift_dr, capture_ir, shift_ir;

  assign sel_idcode = (ir_q == OP_IDCODE);
  assign sel_user   = (ir_q == OP_USER) && !sel_idcode;
  assign sel_byp    = !sel_idcode && !sel_user;
  assign capture_dr = (state_q == CaptureDr);
  assign shift_dr   = (state_q == ShiftDr);
  assign capture_ir = (state_q == CaptureIr);
  assign shift_ir   = (state_q == ShiftIr);

  jtag_shift_reg #(.WIDTH(IR_WIDTH)) u_ir_sr (
    .clk       (tck),
    .rst_n     (rst_n),
    .capture   (capture_ir),
    .shift     (shift_ir),
    .din       (IR_CAPTURE),
    .serial_in (tdi),
    .q         (ir_sr)
  );

  jtag_shift_reg #(.WIDTH(32)) u_id_sr (
    .clk       (tck),
    .rst_n     (rst_n),
    .capture   (capture_dr & sel_idcode),
    .shift     (shift_dr & sel_idcode),
    .din       (IDCODE),
    .serial_in (tdi),
    .q         (id_sr)
  );

  jtag_shift_reg #(.WIDTH(USER_DR_WIDTH)) u_usr_sr (
    .clk       (tck),
    .rst_n     (rst_n),
    .capture   (capture_dr & sel_user),
    .shift     (shift_dr & sel_user),
    .din       (user_capture),
    .serial_in (tdi),
    .q         (usr_sr)
  );

  assign unused_id = ^id_sr[31:1];

  always_comb begin
    state_d       = tap_next(state_q, tms);
    ir_d          = ir_q;
    byp_d         = byp_q;
    user_update_d = user_update_q;
    user_valid_d  = 1'b0;

    // ir reloads one cycle after TMS entry into TestLogicReset; the new opcode applies from the state after UpdateIr.
    if (state_q == TestLogicReset) begin
      ir_d = OP_IDCODE;
    end else if (state_q == UpdateIr) begin
      ir_d = ir_sr;
    end

    if (capture_dr && sel_byp) begin
      byp_d = 1'b0;
    end else if (shift_dr && sel_byp) begin
      byp_d = tdi;
    end

    if ((state_q == UpdateDr) && sel_user) begin
      user_update_d = usr_sr;
      user_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge tck) begin
    if (!rst_n) begin
      state_q       <= TestLogicReset;
      ir_q          <= OP_IDCODE;
      byp_q         <= 1'b0;
      user_update_q <= '0;
      user_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      byp_q         <= byp_d;
      user_update_q <= user_update_d;
      user_valid_q  <= user_valid_d;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_sr[0];
    end else if (shift_dr) begin
      if (sel_idcode) begin
        tdo = id_sr[0];
      end else if (sel_user) begin
        tdo = usr_sr[0];
      end else begin
        tdo = byp_q;
      end
    end
  end

  assign tdo_oe            = shift_ir | shift_dr;
  assign state             = state_q;
  assign ir                = ir_q;
  assign in_reset          = (state_q == TestLogicReset);
  assign user_update       = user_update_q;
  assign user_update_valid = user_valid_q;

endmodule
